// File: rtl/uart_tb_tx.sv
// uart_tb_tx: UART transmitter with a small push FIFO in front of it.
// Bytes pushed over valid/ready are buffered, then sent on tx_o as
// start / 8 data bits LSB first / optional parity / 1 or 2 stop bits.
// Frames follow each other with no idle gap while tx_en is high and the
// FIFO holds data.

module uart_tb_tx #(
    parameter int BAUD_DIV   = 32,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_en,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          word_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = 1'(PARITY_ODD);

    // Refuse to elaborate with parameter values the bit timing or FIFO cannot support.
    if (BAUD_DIV < 2) begin : gBadBaud
        $error("uart_tb_tx: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
        $error("uart_tb_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tb_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW:0]   wrPtr_q, wrPtr_d;
    logic [AW:0]   rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic [7:0]    headData;

    // Serializer state
    state_t        state_q;
    logic [CW-1:0] baudCnt_q;
    logic [2:0]    bitIdx_q;
    logic          stopIdx_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic          baudLast;
    logic          frameLast;

    assign fifoFull  = (level_q == LW'(FIFO_DEPTH));
    assign fifoEmpty = (level_q == '0);
    assign push      = valid_i && !fifoFull;
    assign headData  = fifoMem_q[rdPtr_q[AW-1:0]];

    assign baudLast  = (baudCnt_q == BAUD_LAST);
    assign frameLast = (state_q == STOP) && baudLast && (stopIdx_q == STOP_LAST);

    // A byte leaves the FIFO either from IDLE or right at the end of the
    // previous frame's last stop cycle, so consecutive frames abut.
    assign pop = tx_en && !fifoEmpty && ((state_q == IDLE) || frameLast);

    // Pointer and level next-state; a refused push while full leaves only the pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push) begin
            wrPtr_d = wrPtr_q + (AW+1)'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + (AW+1)'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers and occupancy; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // FIFO data array; contents only matter between a push and its pop.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

    // Frame sequencer: every bit is held for BAUD_DIV cycles, outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baudCnt_q <= '0;
                    if (pop) begin
                        state_q   <= START;
                        shift_q   <= headData;
                        parity_q  <= (^headData) ^ ODD_BIT;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q   <= STOP;
                                stopIdx_q <= 1'b0;
                                tx_q      <= 1'b1;
                            end
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        state_q   <= STOP;
                        stopIdx_q <= 1'b0;
                        tx_q      <= 1'b1;
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        if (stopIdx_q == STOP_LAST) begin
                            done_q <= 1'b1;
                            if (pop) begin
                                state_q  <= START;
                                shift_q  <= headData;
                                parity_q <= (^headData) ^ ODD_BIT;
                                tx_q     <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            stopIdx_q <= 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    baudCnt_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = !fifoFull;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign word_done_o  = done_q;
    assign fifo_level_o = level_q;

endmodule

// File: doc/uart_tb_tx.md
Name: uart_tb_tx

Overview:
Synthesizable UART transmitter. It is the driving end of the serial link whose receive side is uart_tb_rx.
- Accepts bytes over a valid/ready push interface into a small FIFO.
- Serializes them on tx_o as start / 8 data bits (LSB first) / optional parity / stop frames.
- Used in pulpino benches to stimulate the uart_rx pin of pulpino_top, and for loopback checks against uart_tb_rx.

Parameters:
BAUD_DIV, 32, clock cycles per bit (25 MHz / 781250 baud); legal values are >= 2, elaboration $error otherwise
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 4, byte entries in the transmit FIFO, power of two >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  1 = frames may start; 0 = finish the current frame, then hold idle
data_i  input  8  byte to transmit
valid_i  input  1  data_i valid
ready_o  output  1  FIFO not full; a push occurs when valid_i & ready_o
tx_o  output  1  serial line, idle high
busy_o  output  1  a frame is in progress (state != IDLE)
word_done_o  output  1  one-cycle pulse after the last stop-bit period of each frame
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - tx_o=1, busy_o=0, word_done_o=0, ready_o=1, fifo_level_o=0.
  - FIFO is flushed, state=IDLE, baud counter=0.
  - Assertion mid-frame drives tx_o high immediately and abandons the frame.
- FIFO:
  - Circular buffer; pointers carry one extra wrap bit.
  - full = (level==FIFO_DEPTH); ready_o = !full, combinational from registered level.
  - Push and pop in the same cycle: level unchanged. When full, the push is refused and only the pop takes effect.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - If tx_en && level>0: pop the head into the shift register, compute parity, go to START.
  - tx_o goes low on the next cycle.
- Bit timing:
  - Each bit holds tx_o for exactly BAUD_DIV cycles, counted by a 0..BAUD_DIV-1 counter.
  - Counter reloads to 0 on every bit transition.
- START: tx_o=0, then DATA.
- DATA:
  - 8 bits, tx_o = shift[0], shift right after each bit period; a bit index counts 0..7.
  - Then PARITY if PARITY_EN, else STOP.
- PARITY: tx_o = ^data XOR PARITY_ODD.
- STOP: tx_o=1 for STOP_BITS*BAUD_DIV cycles.
- End of the last stop cycle:
  - word_done_o pulses for 1 cycle.
  - If tx_en && level>0: pop and enter START directly, with no idle gap between frames.
  - Otherwise enter IDLE.
- Frame length = (10 + PARITY_EN + STOP_BITS - 1) * BAUD_DIV cycles.
- tx_en deasserted mid-frame: the current frame completes unchanged and no new pop occurs. Reasserting tx_en resumes from the FIFO head.
- A push to an empty FIFO while in IDLE with tx_en=1 is popped on the following cycle. The pop never happens in the same cycle as the push.
- data_i is sampled only on accepted pushes. Bytes are transmitted in push order.

Test Plan:
- Single byte, BAUD_DIV=32: push 0xA5 with tx_en=1 -> tx_o low for 32 cycles, then data bits 1,0,1,0,0,1,0,1 at 32 cycles each, then high for 32. word_done_o pulses 320 cycles after the falling edge; busy_o drops with the pulse.
- Parity, PARITY_EN=1: byte 0x07 with PARITY_ODD=0 -> parity bit 1. PARITY_ODD=1 -> parity bit 0. Frame length is 352 cycles.
- FIFO full, tx_en=0: push 4 bytes -> fifo_level_o=4 and ready_o=0; a 5th push is refused. Raising tx_en sends the 4 bytes back-to-back with no idle cycles between stop and start; word_done_o pulses 4 times, 320 cycles apart.
- tx_en dropped mid-DATA of byte 1 with 2 bytes queued -> byte 1 completes, tx_o stays high, level stays 1. Re-enabling sends byte 2.
- rst_n asserted mid-DATA -> tx_o=1 in the same timestep, level=0, busy_o=0. After release, a new push of 0x3C transmits correctly.
- Loopback into uart_tb_rx (BAUD_RATE 781250, PARITY_EN 0): bytes 0x00, 0xFF, 0x55, 0x0A are received identically and in order.
